regfile_sb: RTL and testbench
=============================

# regfile_sb

Clocked, parametrised general-purpose register file for the datapath, sitting between instruction decode and the ALU. It provides one write port, two combinational read ports, a per-register busy scoreboard for in-flight results, and a multi-cycle hardware clear sweep. It is the synchronous successor to the current 8×13 latch-style register file: writes commit on the clock edge, and the hardwired-zero register and write-to-read bypass are optional.

## Interface
- DATA_W, 13, register width in bits
- ADDR_W, 3, register pointer width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1, register 0 reads 0 and ignores writes and reservations

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- WriteFlag  in  1  write enable for R1
- R1  in  ADDR_W  write pointer
- ALU_Result  in  DATA_W  write data
- R2, R3  in  ADDR_W  read pointers
- RegData2, RegData3  out  DATA_W  read data for R2 / R3, combinational
- ReserveEn  in  1  mark register RsvAddr busy (result pending)
- RsvAddr  in  ADDR_W  reservation pointer
- Busy2, Busy3  out  1  scoreboard bit of R2 / R3, combinational
- ClearReq  in  1  start clear sweep (level-sampled in IDLE)
- ClearBusy  out  1  sweep in progress
- WrDrop  out  1  combinational; high when WriteFlag or ReserveEn is presented while the sweep is active

## Operation
- Storage: DEPTH × DATA_W registers `regs`, DEPTH-bit `busy`, sweep FSM {IDLE, SWEEP}, ADDR_W-bit sweep pointer `ptr`.
- Reset (priority over everything): all regs = 0, busy = 0, state = IDLE, ptr = 0. ClearBusy resets to 0. WrDrop is 0 while Reset is held.
- IDLE, WriteFlag=1: at the edge, regs[R1] <= ALU_Result and busy[R1] <= 0.
- IDLE, ReserveEn=1: at the edge, busy[RsvAddr] <= 1.
- Same edge, WriteFlag and ReserveEn to the same address: data is written and busy ends at 1, because the new producer wins.
- ZERO_REG=1: writes and reservations to address 0 have no effect. RegData*/Busy* for address 0 are always 0.
- Reads: RegData2 = regs[R2], RegData3 = regs[R3]. Busy2/Busy3 = busy[R2]/busy[R3].
- Sweep FSM:
  - IDLE, ClearReq=1 → SWEEP, ptr <= 0.
  - In SWEEP, each edge: regs[ptr] <= 0, busy[ptr] <= 0, ptr <= ptr+1.
  - When ptr = DEPTH-1, that edge clears the last entry and the FSM returns to IDLE with ptr <= 0 (pointer wrap).
- ClearBusy = (state == SWEEP).
- In SWEEP, WriteFlag and ReserveEn are dropped: no state change, and WrDrop = 1 that cycle. Reads remain valid and return partially cleared contents.
- ClearReq while in SWEEP is ignored. ClearReq held high on the exit edge starts a new sweep on the next IDLE cycle.

## Timing
- Write latency is 1 cycle: data is visible on RegData* in the cycle after the WriteFlag edge. With bypass (see Configuration), it is visible in the same cycle.
- Reservation latency is 1 cycle: Busy* rises in the cycle after the ReserveEn edge and has no bypass.
- Sweep duration is exactly DEPTH cycles of ClearBusy=1. The first cleared entry is visible one cycle after the ClearReq edge.
- Reset asserted mid-sweep: at the next edge the FSM is in IDLE and all registers are 0.
- No combinational path from ClearReq to any output.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If WriteFlag=1, the FSM is in IDLE, R1==R2, and the write is not suppressed by ZERO_REG, then RegData2 = ALU_Result in the same cycle. The same rule applies to R3.
  - Busy2/Busy3 read 0 when the matching read address is being written that cycle, unless ReserveEn targets the same address that cycle.
- REGFILE_BYPASS_EN undefined: reads return stored contents only, with 1-cycle write-to-read latency.

## Test plan
- Reset, then write R1=5 with 0x1ABC. Next cycle R2=5 → RegData2=0x1ABC and Busy2=0. All other addresses read 0.
- Same-cycle write R1=3 with 0x0055 and read R2=3:
  - With REGFILE_BYPASS_EN: RegData2=0x0055 that cycle.
  - Without it: the old value that cycle, then 0x0055 the next cycle.
- ReserveEn on RsvAddr=4 → Busy on address 4 = 1 the next cycle. A later write to 4 with 0x0007 → busy on 4 = 0 and data = 0x0007. A reserve and a write to 6 on the same edge → busy on 6 = 1 and data written.
- Fill all 8 registers with nonzero values, then pulse ClearReq:
  - ClearBusy is high for exactly 8 cycles.
  - Register k reads 0 from cycle k+1 after the ClearReq edge.
  - A WriteFlag during the sweep gives WrDrop=1 and the data is not stored.
- Reset on sweep cycle 3 → next cycle ClearBusy=0 and all registers read 0. A fresh ClearReq afterwards again runs 8 cycles.
- ZERO_REG=1: write 0x1FFF to address 0 and ReserveEn on address 0 → RegData/Busy for address 0 stay 0. This holds both with and without REGFILE_BYPASS_EN.

Source files
------------

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Clocked register file with one write port, two combinational
//               read ports, a per-register busy scoreboard and a multi-cycle
//               clear sweep. Optional write-to-read bypass under the macro
//               REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial synchronous release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int DATA_W   = 13,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteFlag,
    input  logic [ADDR_W-1:0] R1,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic [ADDR_W-1:0] R2,
    input  logic [ADDR_W-1:0] R3,
    output logic [DATA_W-1:0] RegData2,
    output logic [DATA_W-1:0] RegData3,
    input  logic              ReserveEn,
    input  logic [ADDR_W-1:0] RsvAddr,
    output logic              Busy2,
    output logic              Busy3,
    input  logic              ClearReq,
    output logic              ClearBusy,
    output logic              WrDrop
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);
    localparam bit                c_ZERO = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_clear_busy;

    logic w_idle;
    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_zero2;
    logic w_zero3;
    logic w_byp2;
    logic w_byp3;
    logic w_bsy_kill2;
    logic w_bsy_kill3;

    assign w_idle   = (r_state == S_IDLE);
    // Writes and reservations are only honoured outside the sweep
    assign w_wr_ok  = WriteFlag & w_idle & ~(c_ZERO & (R1 == '0));
    assign w_rsv_ok = ReserveEn & w_idle & ~(c_ZERO & (RsvAddr == '0));
    assign w_zero2  = c_ZERO & (R2 == '0);
    assign w_zero3  = c_ZERO & (R3 == '0);

`ifdef REGFILE_BYPASS_EN
    assign w_byp2      = w_wr_ok & (R1 == R2);
    assign w_byp3      = w_wr_ok & (R1 == R3);
    // A same-cycle reservation of the read address keeps the stored busy bit
    assign w_bsy_kill2 = w_byp2 & ~(w_rsv_ok & (RsvAddr == R2));
    assign w_bsy_kill3 = w_byp3 & ~(w_rsv_ok & (RsvAddr == R3));
`else
    assign w_byp2      = 1'b0;
    assign w_byp3      = 1'b0;
    assign w_bsy_kill2 = 1'b0;
    assign w_bsy_kill3 = 1'b0;
`endif

    assign RegData2 = w_zero2 ? '0 : (w_byp2 ? ALU_Result : r_regs[R2]);
    assign RegData3 = w_zero3 ? '0 : (w_byp3 ? ALU_Result : r_regs[R3]);
    assign Busy2    = ~w_zero2 & r_busy[R2] & ~w_bsy_kill2;
    assign Busy3    = ~w_zero3 & r_busy[R3] & ~w_bsy_kill3;

    assign ClearBusy = r_clear_busy;
    assign WrDrop    = ~Reset & r_clear_busy & (WriteFlag | ReserveEn);

    // Reservation is applied after the write so a same-edge producer wins
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else if (r_state == S_SWEEP) begin
            r_regs[r_ptr] <= '0;
            r_busy[r_ptr] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[R1] <= ALU_Result;
                r_busy[R1] <= 1'b0;
            end
            if (w_rsv_ok) begin
                r_busy[RsvAddr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ClearReq) begin
                        r_state      <= S_SWEEP;
                        r_ptr        <= '0;
                        r_clear_busy <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (r_ptr == c_LAST) begin
                        r_state      <= S_IDLE;
                        r_ptr        <= '0;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ptr        <= '0;
                    r_clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (ZERO_REG off/on) share stimulus and
// are compared every cycle against an array model, plus literal checks.
`default_nettype none

module tb_regfile_sb;

    localparam int DW = 13;
    localparam int AW = 3;
    localparam int N  = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          Clk        = 1'b0;
    logic          Reset      = 1'b1;
    logic          WriteFlag  = 1'b0;
    logic          ReserveEn  = 1'b0;
    logic          ClearReq   = 1'b0;
    logic [AW-1:0] R1         = '0;
    logic [AW-1:0] R2         = '0;
    logic [AW-1:0] R3         = '0;
    logic [AW-1:0] RsvAddr    = '0;
    logic [DW-1:0] ALU_Result = '0;

    logic [DW-1:0] rd2 [2];
    logic [DW-1:0] rd3 [2];
    logic          bsy2 [2];
    logic          bsy3 [2];
    logic          clr_busy [2];
    logic          wr_drop [2];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut (
        .Clk(Clk), .Reset(Reset), .WriteFlag(WriteFlag), .R1(R1),
        .ALU_Result(ALU_Result), .R2(R2), .R3(R3),
        .RegData2(rd2[0]), .RegData3(rd3[0]),
        .ReserveEn(ReserveEn), .RsvAddr(RsvAddr),
        .Busy2(bsy2[0]), .Busy3(bsy3[0]),
        .ClearReq(ClearReq), .ClearBusy(clr_busy[0]), .WrDrop(wr_drop[0])
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dut_z (
        .Clk(Clk), .Reset(Reset), .WriteFlag(WriteFlag), .R1(R1),
        .ALU_Result(ALU_Result), .R2(R2), .R3(R3),
        .RegData2(rd2[1]), .RegData3(rd3[1]),
        .ReserveEn(ReserveEn), .RsvAddr(RsvAddr),
        .Busy2(bsy2[1]), .Busy3(bsy3[1]),
        .ClearReq(ClearReq), .ClearBusy(clr_busy[1]), .WrDrop(wr_drop[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [2][N];
    logic          m_busy [2][N];
    bit            m_sweep = 1'b0;
    int            m_next  = 0;
    bit            m_valid = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int z = 0; z < 2; z++)
                for (int a = 0; a < N; a++) begin
                    m_regs[z][a] = '0;
                    m_busy[z][a] = 1'b0;
                end
            m_sweep = 1'b0;
            m_next  = 0;
            m_valid = 1'b1;
        end else if (m_sweep) begin
            for (int z = 0; z < 2; z++) begin
                m_regs[z][m_next] = '0;
                m_busy[z][m_next] = 1'b0;
            end
            m_next++;
            if (m_next == N) begin
                m_sweep = 1'b0;
                m_next  = 0;
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (WriteFlag && !(z == 1 && R1 == '0)) begin
                    m_regs[z][R1] = ALU_Result;
                    m_busy[z][R1] = 1'b0;
                end
                if (ReserveEn && !(z == 1 && RsvAddr == '0))
                    m_busy[z][RsvAddr] = 1'b1;
            end
            if (ClearReq) begin
                m_sweep = 1'b1;
                m_next  = 0;
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input int z, input logic [AW-1:0] a);
        if (z == 1 && a == '0) return '0;
        if (BYP && WriteFlag && !m_sweep && R1 == a) return ALU_Result;
        return m_regs[z][a];
    endfunction

    function automatic logic exp_busy(input int z, input logic [AW-1:0] a);
        if (z == 1 && a == '0) return 1'b0;
        if (BYP && WriteFlag && !m_sweep && R1 == a && !(ReserveEn && RsvAddr == a)) return 1'b0;
        return m_busy[z][a];
    endfunction

    always @(negedge Clk) begin
        if (m_valid) begin
            for (int z = 0; z < 2; z++) begin
                chk($sformatf("RegData2_z%0d", z), 32'(rd2[z]), 32'(exp_data(z, R2)));
                chk($sformatf("RegData3_z%0d", z), 32'(rd3[z]), 32'(exp_data(z, R3)));
                chk($sformatf("Busy2_z%0d", z), 32'(bsy2[z]), 32'(exp_busy(z, R2)));
                chk($sformatf("Busy3_z%0d", z), 32'(bsy3[z]), 32'(exp_busy(z, R3)));
                chk($sformatf("ClearBusy_z%0d", z), 32'(clr_busy[z]), 32'(m_sweep));
                chk($sformatf("WrDrop_z%0d", z), 32'(wr_drop[z]),
                    32'(!Reset && m_sweep && (WriteFlag || ReserveEn)));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill(input int k);
        return DW'(32'h0A00 + k + 1);
    endfunction

    task automatic run_sweep(input bit with_fill);
        int cnt;
        cnt = 0;
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        for (int j = 0; j < 20; j++) begin
            R2 = AW'(j == 0 ? 0 : j - 1);
            R3 = AW'(j < N ? j : 0);
            WriteFlag  = with_fill && (j == 2);
            R1         = '0;
            ALU_Result = 13'h1234;
            #2;
            if (!clr_busy[0]) break;
            cnt++;
            if (j >= 1) chk("sweep_cleared", 32'(rd2[0]), 32'h0);
            if (with_fill && j < N) chk("sweep_pending", 32'(rd3[0]), 32'(fill(j)));
            if (with_fill && j == 2) chk("sweep_wrdrop", 32'(wr_drop[0]), 32'h1);
            step();
        end
        WriteFlag = 1'b0;
        chk("sweep_len", 32'(cnt), 32'(N));
    endtask

    initial begin
        step();
        step();
        Reset = 1'b0;

        // write 5, then read every address
        WriteFlag = 1'b1; R1 = 3'd5; ALU_Result = 13'h1ABC; R2 = 3'd0; R3 = 3'd1;
        step();
        WriteFlag = 1'b0;
        for (int a = 0; a < N; a++) begin
            R2 = AW'(a);
            R3 = AW'(N - 1 - a);
            #2;
            chk("t1_read", 32'(rd2[0]), (a == 5) ? 32'h1ABC : 32'h0);
            if (a == 5) chk("t1_busy", 32'(bsy2[0]), 32'h0);
            step();
        end

        // same-cycle write/read of address 3
        WriteFlag = 1'b1; R1 = 3'd3; ALU_Result = 13'h0055; R2 = 3'd3; R3 = 3'd3;
        #2;
        chk("t2_same_cycle", 32'(rd2[0]), BYP ? 32'h0055 : 32'h0);
        step();
        WriteFlag = 1'b0;
        #2;
        chk("t2_next_cycle", 32'(rd2[0]), 32'h0055);
        step();

        // reservation on 4, then write clears it
        ReserveEn = 1'b1; RsvAddr = 3'd4; R2 = 3'd4; R3 = 3'd6;
        step();
        ReserveEn = 1'b0;
        #2;
        chk("t3_rsv_busy", 32'(bsy2[0]), 32'h1);
        step();
        WriteFlag = 1'b1; R1 = 3'd4; ALU_Result = 13'h0007;
        #2;
        chk("t3_wr_busy_now", 32'(bsy2[0]), BYP ? 32'h0 : 32'h1);
        step();
        WriteFlag = 1'b0;
        #2;
        chk("t3_wr_busy", 32'(bsy2[0]), 32'h0);
        chk("t3_wr_data", 32'(rd2[0]), 32'h0007);
        step();

        // reserve and write to 6 on the same edge
        WriteFlag = 1'b1; R1 = 3'd6; ALU_Result = 13'h0AAA;
        ReserveEn = 1'b1; RsvAddr = 3'd6; R2 = 3'd6;
        #2;
        chk("t4_busy_now", 32'(bsy2[0]), 32'h0);
        step();
        WriteFlag = 1'b0; ReserveEn = 1'b0;
        #2;
        chk("t4_busy", 32'(bsy2[0]), 32'h1);
        chk("t4_data", 32'(rd2[0]), 32'h0AAA);
        step();

        // fill and sweep with a dropped write
        for (int k = 0; k < N; k++) begin
            WriteFlag = 1'b1; R1 = AW'(k); ALU_Result = fill(k);
            step();
        end
        WriteFlag = 1'b0;
        run_sweep(1'b1);
        R2 = 3'd0;
        #1;
        chk("drop_not_stored", 32'(rd2[0]), 32'h0);
        step();

        // reset in the middle of a sweep
        for (int k = 0; k < 3; k++) begin
            WriteFlag = 1'b1; R1 = AW'(k + 4); ALU_Result = fill(k);
            step();
        end
        WriteFlag = 1'b0;
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        step(); step(); step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #2;
        chk("rst_mid_sweep_clr", 32'(clr_busy[0]), 32'h0);
        for (int a = 0; a < N; a++) begin
            R2 = AW'(a);
            #1;
            chk("rst_mid_sweep_data", 32'(rd2[0]), 32'h0);
            step();
        end
        run_sweep(1'b0);
        step();

        // hardwired zero register
        WriteFlag = 1'b1; R1 = 3'd0; ALU_Result = 13'h1FFF;
        ReserveEn = 1'b1; RsvAddr = 3'd0; R2 = 3'd0; R3 = 3'd0;
        #2;
        chk("z0_data_now", 32'(rd2[1]), 32'h0);
        chk("z0_busy_now", 32'(bsy2[1]), 32'h0);
        step();
        WriteFlag = 1'b0; ReserveEn = 1'b0;
        #2;
        chk("z0_data", 32'(rd2[1]), 32'h0);
        chk("z0_busy", 32'(bsy2[1]), 32'h0);
        chk("nz0_data", 32'(rd2[0]), 32'h1FFF);
        chk("nz0_busy", 32'(bsy2[0]), 32'h1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
